// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: fetch/decode/execute sequencer driving the shared-bus CPU strobes
// Strobes are decoded combinationally from state and gated by rst_n so nothing fires during reset.
module cpu_ctrl_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        pc_oe,
  output logic        pcinc,
  output logic        pcload,
  output logic        ir_oe,
  output logic        mar_load,
  output logic        ir_load,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        acc_load,
  output logic        acc_oe,
  output logic [1:0]  alu_op,
  output logic        halted,
  output logic        fault,
  output logic        illegal,
  output logic [2:0]  state_dbg
);
  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    DECODE = 3'd2,
    EXEC0  = 3'd3,
    EXEC1  = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [3:0] op;
  logic is_sta, is_mem, take, wait_st, expire, ex1;

  assign op      = ir[15:12];
  assign is_sta  = op == 4'h2;
  assign is_mem  = op inside {[4'h1:4'h4]};
  assign take    = op == 4'h5 || (op == 4'h6 && zero_flag) || (op == 4'h7 && !zero_flag);
  assign wait_st = state == FETCH1 || state == EXEC1;
  assign expire  = wait_st && !mem_ready && cnt == CNT_W'(MEM_TIMEOUT - 1);
  assign ex1     = rst_n && state == EXEC1;

  assign pc_oe     = rst_n && state == FETCH0;
  assign mar_load  = rst_n && (state == FETCH0 || state == EXEC0);
  assign ir_load   = rst_n && state == FETCH1 && mem_ready;
  assign pcinc     = ir_load;
  assign pcload    = rst_n && state == DECODE && take;
  assign ir_oe     = pcload || (rst_n && state == EXEC0);
  assign mem_rd    = (rst_n && state == FETCH1) || (ex1 && !is_sta);
  assign mem_wr    = ex1 && is_sta;
  assign acc_oe    = mem_wr;
  assign acc_load  = ex1 && !is_sta && mem_ready;
  assign alu_op    = !ex1 ? 2'b00 : op == 4'h3 ? 2'b01 : op == 4'h4 ? 2'b10 : 2'b00;
  assign halted    = rst_n && state == HALT;
  assign illegal   = rst_n && state == DECODE && op inside {[4'h8:4'hE]};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH0;
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        FETCH0: state <= FETCH1;
        FETCH1, EXEC1:
          if (mem_ready) begin
            state <= state == FETCH1 ? DECODE : FETCH0;
            cnt   <= '0;
          end else if (expire) begin
            state <= HALT;
            fault <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        DECODE: state <= op == 4'hF ? HALT : is_mem ? EXEC0 : FETCH0;
        EXEC0:  state <= EXEC1;
        HALT:   state <= HALT;
        default: state <= FETCH0;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: instruction-level reference model expands each instruction into its expected per-cycle strobe trace
module tb_cpu_ctrl_seq;
  localparam int TO = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] ir = '0;
  logic zero_flag = 1'b0, mem_ready = 1'b0;
  logic pc_oe, pcinc, pcload, ir_oe, mar_load, ir_load, mem_rd, mem_wr, acc_load, acc_oe;
  logic [1:0] alu_op;
  logic halted, fault, illegal;
  logic [2:0] state_dbg;

  cpu_ctrl_seq #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .zero_flag(zero_flag), .mem_ready(mem_ready),
    .pc_oe(pc_oe), .pcinc(pcinc), .pcload(pcload), .ir_oe(ir_oe), .mar_load(mar_load),
    .ir_load(ir_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .acc_load(acc_load), .acc_oe(acc_oe),
    .alu_op(alu_op), .halted(halted), .fault(fault), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_oe, pcinc, pcload, ir_oe, mar_load, ir_load, mem_rd, mem_wr, acc_load, acc_oe;
    logic [1:0] alu_op;
    logic halted, illegal, fault;
    logic [2:0] st;
  } obs_t;

  obs_t act;
  assign act = {pc_oe, pcinc, pcload, ir_oe, mar_load, ir_load, mem_rd, mem_wr, acc_load, acc_oe,
                alu_op, halted, illegal, fault, state_dbg};

  // PC sits outside the controller and updates on the falling edge from the strobes
  logic [5:0] pc;
  always @(negedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (pcload) pc <= ir[5:0];
    else if (pcinc) pc <= pc + 6'd1;

  obs_t expq[$];
  bit rdyq[$];
  int total = 0, bad = 0;

  function automatic obs_t z(logic [2:0] st);
    obs_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic void push(obs_t e, bit r);
    expq.push_back(e);
    rdyq.push_back(r);
  endfunction

  function automatic void halt_tail(bit f);
    obs_t e = z(3'd5);
    e.halted = 1'b1;
    e.fault = f;
    for (int k = 0; k < 3; k++) push(e, 1'($urandom));
  endfunction

  function automatic void build(logic [15:0] i, bit zf, int fw, int ew);
    logic [3:0] op = i[15:12];
    bit tk = op == 4'h5 || (op == 4'h6 && zf) || (op == 4'h7 && !zf);
    obs_t e;
    e = z(3'd0); e.pc_oe = 1; e.mar_load = 1; push(e, 1'($urandom));
    e = z(3'd1); e.mem_rd = 1;
    for (int k = 0; k < fw && k < TO; k++) push(e, 1'b0);
    if (fw >= TO) begin halt_tail(1'b1); return; end
    e.ir_load = 1; e.pcinc = 1; push(e, 1'b1);
    e = z(3'd2); e.ir_oe = tk; e.pcload = tk; e.illegal = op inside {[4'h8:4'hE]}; push(e, 1'($urandom));
    if (op == 4'hF) begin halt_tail(1'b0); return; end
    if (!(op inside {[4'h1:4'h4]})) return;
    e = z(3'd3); e.ir_oe = 1; e.mar_load = 1; push(e, 1'($urandom));
    e = z(3'd4);
    if (op == 4'h2) begin e.mem_wr = 1; e.acc_oe = 1; end
    else begin e.mem_rd = 1; e.alu_op = op == 4'h3 ? 2'd1 : op == 4'h4 ? 2'd2 : 2'd0; end
    for (int k = 0; k < ew && k < TO; k++) push(e, 1'b0);
    if (ew >= TO) begin halt_tail(1'b1); return; end
    e.acc_load = op != 4'h2; push(e, 1'b1);
  endfunction

  task automatic play(string nm);
    for (int k = 0; k < expq.size(); k++) begin
      mem_ready = rdyq[k];
      @(negedge clk);
      total++;
      if (act !== expq[k]) begin
        bad++;
        $display("FAIL %s cyc%0d got=%h exp=%h", nm, k, act, expq[k]);
      end
      @(posedge clk); #1;
    end
    expq.delete();
    rdyq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run(logic [15:0] i, bit zf, int fw, int ew, string nm);
    logic [3:0] op = i[15:12];
    bit tk = op == 4'h5 || (op == 4'h6 && zf) || (op == 4'h7 && !zf);
    bit stop = fw >= TO || op == 4'hF || (ew >= TO && op inside {[4'h1:4'h4]});
    logic [5:0] p0 = pc;
    logic [5:0] pexp = fw >= TO ? p0 : tk ? i[5:0] : p0 + 6'd1;
    ir = i;
    zero_flag = zf;
    build(i, zf, fw, ew);
    play(nm);
    total++;
    if (pc !== pexp) begin
      bad++;
      $display("FAIL %s_pc got=%h exp=%h", nm, pc, pexp);
    end
    if (stop) do_reset();
    else begin
      total++;
      if (state_dbg !== 3'd0) begin
        bad++;
        $display("FAIL %s_end got=%0d exp=0", nm, state_dbg);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ir = 16'(($urandom));
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (act !== z(3'd0)) begin bad++; $display("FAIL reset got=%h exp=%h", act, z(3'd0)); end
    rst_n = 1'b1;
  endtask

  task automatic test_nop();
    for (int k = 0; k < 3; k++) run(16'h0000, 1'b0, 0, 0, "nop");
  endtask

  task automatic test_jumps();
    run(16'h5025, 1'b0, 0, 0, "jmp");
    run(16'h6010, 1'b0, 0, 0, "jz0");
    run(16'h6010, 1'b1, 0, 0, "jz1");
    run(16'h7033, 1'b1, 0, 0, "jnz1");
    run(16'h7033, 1'b0, 1, 0, "jnz0");
  endtask

  task automatic test_mem_ops();
    run(16'h3008, 1'b0, 0, 3, "add_wait");
    run(16'h1004, 1'b0, 2, 0, "lda");
    run(16'h4011, 1'b0, 0, 1, "sub");
    run(16'h2012, 1'b0, 1, 2, "sta");
  endtask

  task automatic test_illegal();
    run(16'h9000, 1'b0, 0, 0, "illegal");
    run(16'h0000, 1'b0, 0, 0, "after_illegal");
    run(16'hE123, 1'b1, 0, 0, "illegal_e");
  endtask

  task automatic test_timeout();
    run(16'h0000, 1'b0, TO - 1, 0, "fetch_edge");
    run(16'h4000, 1'b0, 0, TO - 1, "exec_edge");
    run(16'(($urandom)), 1'b0, TO, 0, "fetch_to");
    run(16'h1007, 1'b0, 0, TO, "exec_to");
    total++;
    if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", fault); end
    run(16'hF000, 1'b0, 0, 0, "hlt");
  endtask

  task automatic test_async_reset();
    ir = 16'h2015;
    build(16'h2015, 1'b0, 0, TO);
    expq = expq[0:5];
    rdyq = rdyq[0:5];
    play("sta_pre");
    mem_ready = 1'b0;
    #2;
    total++;
    if (mem_wr !== 1'b1) begin bad++; $display("FAIL sta_wr got=%b exp=1", mem_wr); end
    rst_n = 1'b0;
    #1;
    total++;
    if (act !== z(3'd0)) begin bad++; $display("FAIL async_rst got=%h exp=%h", act, z(3'd0)); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(16'h0000, 1'b0, 0, 0, "post_rst");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      logic [15:0] i = 16'($urandom);
      int fw = $urandom_range(0, 9) == 0 ? TO - 1 : $urandom_range(0, 3);
      int ew = $urandom_range(0, 9) == 0 ? TO - 1 : $urandom_range(0, 3);
      run(i, 1'($urandom), fw, ew, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_jumps();
    test_mem_ops();
    test_illegal();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Instruction-sequencing controller for the simple 16-bit-bus CPU. It drives the PC control strobes (pcinc, pcload, pc_oe), the MAR, IR, memory and accumulator strobes, and runs each instruction through fetch/decode/execute. Memory accesses use a ready handshake with a timeout. The block sits beside the PC, IR, ACC and ALU, and all of them share the 16-bit bus.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for mem_ready in one access before a fault halt (1..255).
CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  system clock; the FSM advances on the rising edge.
rst_n  in  1  asynchronous active-low reset.
ir  in  16  current instruction register; opcode = ir[15:12].
zero_flag  in  1  accumulator-zero flag.
mem_ready  in  1  memory access complete, sampled in the same cycle.
pc_oe  out  1  PC drives bus[5:0].
pcinc  out  1  PC increment strobe.
pcload  out  1  PC load-from-bus strobe.
ir_oe  out  1  IR operand (ir[5:0], zero-extended) drives bus.
mar_load  out  1  MAR loads from bus.
ir_load  out  1  IR loads memory data.
mem_rd  out  1  memory read request.
mem_wr  out  1  memory write request.
acc_load  out  1  ACC loads ALU result.
acc_oe  out  1  ACC drives bus.
alu_op  out  2  ALU function: 00 pass, 01 add, 10 sub.
halted  out  1  core stopped.
fault  out  1  sticky memory-timeout fault.
illegal  out  1  one-cycle pulse on an undefined opcode.
state_dbg  out  3  current state encoding.

Behaviour:
- Reset (async, rst_n=0): state=FETCH0, wait counter=0, fault=0.
  - All strobes, halted and illegal are forced to 0 while rst_n=0, regardless of state.
  - Reset asserted mid-access abandons the access. No strobe glitches after deassertion; the first cycle after release is FETCH0.
- Strobe decode: strobes are combinational from state, ir, zero_flag, mem_ready and the counter.
  - Each strobe is high for whole clk cycles only.
  - The PC updates on the falling edge, so one cycle of pcinc or pcload changes the PC exactly once.
  - pcinc and pcload are never high in the same cycle.
- States: FETCH0=0, FETCH1=1, DECODE=2, EXEC0=3, EXEC1=4, HALT=5.
- FETCH0: pc_oe=1, mar_load=1 -> FETCH1.
- FETCH1: mem_rd=1.
  - If mem_ready: ir_load=1, pcinc=1 -> DECODE, counter cleared.
  - Else counter++.
- DECODE (no memory access), by opcode:
  - 0 NOP -> FETCH0.
  - 1 LDA, 2 STA, 3 ADD, 4 SUB -> EXEC0.
  - 5 JMP: ir_oe=1, pcload=1 -> FETCH0.
  - 6 JZ: if zero_flag then ir_oe=1, pcload=1; -> FETCH0.
  - 7 JNZ: as JZ with the condition inverted.
  - F HLT -> HALT.
  - 8-E: illegal=1 for this cycle -> FETCH0 (executes as NOP).
- EXEC0: ir_oe=1, mar_load=1 -> EXEC1.
- EXEC1, by opcode:
  - LDA: mem_rd=1, alu_op=00; on mem_ready acc_load=1.
  - ADD: as LDA with alu_op=01.
  - SUB: as LDA with alu_op=10.
  - STA: acc_oe=1, mem_wr=1; on mem_ready the access is done, no acc_load.
  - On mem_ready -> FETCH0, counter cleared; else counter++.
  - mem_rd/mem_wr stay asserted and stable until mem_ready or timeout.
- Timeout (FETCH1 or EXEC1): a wait cycle without mem_ready while counter==MEM_TIMEOUT-1 -> HALT, fault=1. No completion strobe (ir_load, pcinc, acc_load) is issued.
  - mem_ready in the same cycle the counter would expire: the access completes normally, no fault.
  - mem_ready in the first cycle gives zero wait states.
- HALT: halted=1, all other strobes 0. Only rst_n exits HALT; fault holds until reset.
- alu_op is 00 in every state not listed above.
- Latency:
  - NOP/JMP/JZ/JNZ: 3 cycles.
  - LDA/STA/ADD/SUB: 5 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset release, mem_ready tied 1, ir=0x0000 (NOP) -> state sequence 0,1,2,0; pcinc high exactly 1 cycle per 3; PC 0->1->2.
- ir=0x5025 (JMP 0x25) -> in DECODE ir_oe=1, pcload=1, pcinc=0; the next FETCH0 drives PC=0x25.
- ir=0x6010 (JZ) with zero_flag=0, then zero_flag=1 -> pcload stays 0 in the first run; pcload=1 exactly one cycle in the second.
- ir=0x3008 (ADD), mem_ready low 3 cycles in EXEC1 -> mem_rd held 4 cycles with alu_op=01; acc_load=1 only in the ready cycle; total 8 cycles.
- mem_ready stuck 0 in FETCH1 with MEM_TIMEOUT=15 -> after 15 wait cycles halted=1, fault=1, ir_load and pcinc never asserted; rst_n pulse clears both.
- rst_n asserted mid-EXEC1 of STA -> mem_wr drops immediately (asynchronous); after release, FETCH0 with fault=0. Separately, ir=0x9000 -> illegal pulse of 1 cycle, then normal fetch.
